// File: rtl/packet_buffer_pkg.sv
// Shared types and helpers for the packet buffer drain side.
//   read_state_e : read controller FSM encoding (IDLE / STREAM)
//   next_lane()  : lane index increment with explicit wrap at n-1 -> 0,
//                  safe for lane counts that are not a power of two
package packet_buffer_pkg;

   typedef enum logic {
      READ_IDLE,
      READ_STREAM
   } read_state_e;

   function automatic int unsigned next_lane(input int unsigned idx,
                                             input int unsigned n);
      int unsigned nxt;
      nxt = idx + 1;
      if (nxt >= n) begin
         nxt = 0;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/packet_buffer_read_controller_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : request vector, one bit per requester
//   start_i     : index to start the search from (highest priority)
//   grant_o     : first requesting index found from start_i upward, wrapping
//   any_grant_o : at least one request is set
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [IDX_W-1:0] grant_o,
   output logic             any_grant_o
);

   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      idx     = start_i;
      found   = 1'b0;
      grant_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && req_i[idx]) begin
            found   = 1'b1;
            grant_o = idx;
         end
         // explicit compare so non-power-of-two N wraps correctly
         idx = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
      end
      any_grant_o = found;
   end

endmodule

// File: rtl/packet_buffer_read_controller.sv
// Drain-side controller for the lane packet FIFOs. Counts complete packets per
// lane, grants one lane at a time (round-robin over lanes holding a packet) and
// holds the grant until that lane's last beat is accepted downstream.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   lane_commit_i[i]  : write side finished a packet into lane i
//   lane_valid_i[i]   : lane FIFO output valid
//   lane_last_i[i]    : lane FIFO output last
//   lane_ready_o[i]   : pop qualifier back to lane FIFO i
//   out_ready_i       : downstream ready
//   out_valid_o       : downstream valid
//   out_last_o        : downstream last
//   lane_sel_o        : granted lane, drives the external data mux
//   lane_sel_valid_o  : a grant is active
//   overflow_err_o    : sticky, commit seen at a lane already holding the max
module packet_buffer_read_controller
   import packet_buffer_pkg::*;
#(
   parameter int unsigned NUM_LANES             = 4,
   parameter int unsigned LANE_SELECT_IDX_WIDTH = $clog2(NUM_LANES),
   parameter int unsigned MAX_PACKETS_PER_LANE  = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_LANES-1:0]             lane_commit_i,
   input  logic [NUM_LANES-1:0]             lane_valid_i,
   input  logic [NUM_LANES-1:0]             lane_last_i,
   output logic [NUM_LANES-1:0]             lane_ready_o,
   input  logic                             out_ready_i,
   output logic                             out_valid_o,
   output logic                             out_last_o,
   output logic [LANE_SELECT_IDX_WIDTH-1:0] lane_sel_o,
   output logic                             lane_sel_valid_o,
   output logic                             overflow_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_PACKETS_PER_LANE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PACKETS_PER_LANE);

   read_state_e                      state_r, state_nxt;
   logic [LANE_SELECT_IDX_WIDTH-1:0] lane_sel_r, rr_ptr_r, arb_grant;
   logic                             arb_any;
   logic [NUM_LANES-1:0]             lane_req;
   logic [NUM_LANES-1:0]             lane_dec;
   logic [CNT_W-1:0]                 pkt_count_r [NUM_LANES];
   logic                             overflow_err_r;
   logic                             grant_load, accept_last;

   // Only lanes holding at least one complete packet may be granted.
   always_comb begin
      lane_req = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         lane_req[i] = (pkt_count_r[i] != '0);
      end
   end

   rr_arbiter #(
      .N     (NUM_LANES),
      .IDX_W (LANE_SELECT_IDX_WIDTH)
   ) u_rr_arbiter (
      .req_i       (lane_req),
      .start_i     (rr_ptr_r),
      .grant_o     (arb_grant),
      .any_grant_o (arb_any)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= READ_IDLE;
         lane_sel_r <= '0;
         rr_ptr_r   <= '0;
      end else begin
         state_r <= state_nxt;
         if (grant_load) begin
            lane_sel_r <= arb_grant;
         end
         if (accept_last) begin
            rr_ptr_r <= LANE_SELECT_IDX_WIDTH'(next_lane(32'(lane_sel_r), NUM_LANES));
         end
      end
   end

   always_comb begin
      state_nxt    = state_r;
      grant_load   = 1'b0;
      accept_last  = 1'b0;
      out_valid_o  = 1'b0;
      out_last_o   = 1'b0;
      lane_ready_o = '0;
      lane_dec     = '0;
      case (state_r)
         READ_IDLE: begin
            if (arb_any) begin
               grant_load = 1'b1;
               state_nxt  = READ_STREAM;
            end
         end
         READ_STREAM: begin
            out_valid_o              = lane_valid_i[lane_sel_r];
            out_last_o               = lane_last_i[lane_sel_r];
            lane_ready_o[lane_sel_r] = out_ready_i;
            accept_last = lane_valid_i[lane_sel_r] & lane_last_i[lane_sel_r] & out_ready_i;
            if (accept_last) begin
               lane_dec[lane_sel_r] = 1'b1;
               state_nxt            = READ_IDLE;
            end
         end
         default: state_nxt = READ_IDLE;
      endcase
   end

   // Commit and drain on the same lane in one cycle cancel out. A commit at a
   // full lane is dropped from the count and latches the error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_err_r <= 1'b0;
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pkt_count_r[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_commit_i[i] && (pkt_count_r[i] == CNT_MAX)) begin
               overflow_err_r <= 1'b1;
            end
            if (lane_commit_i[i] && !lane_dec[i] && (pkt_count_r[i] != CNT_MAX)) begin
               pkt_count_r[i] <= pkt_count_r[i] + 1'b1;
            end else if (!lane_commit_i[i] && lane_dec[i]) begin
               pkt_count_r[i] <= pkt_count_r[i] - 1'b1;
            end
         end
      end
   end

   assign lane_sel_o       = lane_sel_r;
   assign lane_sel_valid_o = (state_r == READ_STREAM);
   assign overflow_err_o   = overflow_err_r;

endmodule

// File: tb/tb_packet_buffer_read_controller.sv
// Directed self-checking bench for packet_buffer_read_controller
// (4 lanes, max 2 packets per lane so the overflow path is reachable).
module tb_packet_buffer_read_controller;

   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [NL-1:0] commit, lvalid, llast, lready;
   logic          oready, ovalid, olast, sel_valid, ovf;
   logic [1:0]    sel;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   packet_buffer_read_controller #(
      .NUM_LANES            (NL),
      .MAX_PACKETS_PER_LANE (2)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .lane_commit_i    (commit),
      .lane_valid_i     (lvalid),
      .lane_last_i      (llast),
      .lane_ready_o     (lready),
      .out_ready_i      (oready),
      .out_valid_o      (ovalid),
      .out_last_o       (olast),
      .lane_sel_o       (sel),
      .lane_sel_valid_o (sel_valid),
      .overflow_err_o   (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic expect_grant(input int lane);
      int n = 0;
      while (!sel_valid && n < 8) begin
         cyc();
         settle();
         n++;
      end
      chk("grant_seen", 32'(sel_valid), 1);
      chk($sformatf("grant_lane%0d", lane), 32'(sel), lane);
   endtask

   task automatic do_reset;
      commit = '0;
      lvalid = '0;
      llast  = '0;
      oready = 1'b0;
      rst_ni = 1'b0;
      cyc();
      cyc();
      rst_ni = 1'b1;
      settle();
   endtask

   // A lane may only finish a packet while it still holds one.
   always @(posedge clk) begin
      if (rst_ni && sel_valid && ovalid && olast && oready) begin
         chk("accept_count_nonzero", 32'(dut.pkt_count_r[sel] != '0), 1);
      end
   end

   initial begin
      int order1[4] = '{0, 1, 2, 3};
      int order2[2] = '{0, 3};
      logic pat[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int bi;

      // Reset state, with lane inputs active to show outputs are gated
      rst_ni = 1'b0;
      commit = '0;
      lvalid = '1;
      llast  = '1;
      oready = 1'b1;
      cyc();
      settle();
      chk("rst_sel_valid", 32'(sel_valid), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_out_valid", 32'(ovalid), 0);
      chk("rst_out_last", 32'(olast), 0);
      chk("rst_lane_ready", 32'(lready), 0);
      chk("rst_overflow", 32'(ovf), 0);
      do_reset();

      // Single 4-beat packet on lane 2
      commit = 4'b0100;
      lvalid = 4'b0100;
      oready = 1'b1;
      settle();
      chk("t1_idle_at_commit", 32'(sel_valid), 0);
      cyc();
      commit = '0;
      settle();
      chk("t1_count_after_commit", 32'(dut.pkt_count_r[2]), 1);
      chk("t1_no_grant_yet", 32'(sel_valid), 0);
      cyc();
      for (int b = 1; b <= 4; b++) begin
         llast = (b == 4) ? 4'b0100 : 4'b0000;
         settle();
         chk("t1_sel_valid", 32'(sel_valid), 1);
         chk("t1_sel", 32'(sel), 2);
         chk("t1_out_valid", 32'(ovalid), 1);
         chk("t1_out_last", 32'(olast), (b == 4) ? 1 : 0);
         chk("t1_lane_ready", 32'(lready), 32'h4);
         cyc();
      end
      lvalid = '0;
      llast  = '0;
      settle();
      chk("t1_released", 32'(sel_valid), 0);
      chk("t1_count_drained", 32'(dm_count(2)), 0);
      chk("t1_out_valid_idle", 32'(ovalid), 0);

      // Round-robin across all lanes, then lanes 0 and 3
      do_reset();
      commit = 4'b1111;
      lvalid = 4'b1111;
      llast  = 4'b1111;
      oready = 1'b1;
      cyc();
      commit = '0;
      settle();
      for (int k = 0; k < 4; k++) begin
         expect_grant(order1[k]);
         chk("t2_out_valid", 32'(ovalid), 1);
         chk("t2_out_last", 32'(olast), 1);
         chk("t2_lane_ready", 32'(lready), 1 << order1[k]);
         cyc();
         settle();
         chk("t2_bubble", 32'(sel_valid), 0);
      end
      commit = 4'b1001;
      cyc();
      commit = '0;
      settle();
      for (int k = 0; k < 2; k++) begin
         expect_grant(order2[k]);
         cyc();
         settle();
         chk("t2b_bubble", 32'(sel_valid), 0);
      end
      lvalid = '0;
      llast  = '0;

      // Backpressure on a 3-beat packet in lane 1
      commit = 4'b0010;
      lvalid = 4'b0010;
      cyc();
      commit = '0;
      settle();
      expect_grant(1);
      bi = 0;
      for (int c = 0; c < 5; c++) begin
         oready = pat[c];
         llast  = (bi == 2) ? 4'b0010 : 4'b0000;
         settle();
         chk("t3_grant_held", 32'(sel_valid), 1);
         chk("t3_lane_ready", 32'(lready), pat[c] ? 32'h2 : 32'h0);
         chk("t3_out_valid", 32'(ovalid), 1);
         chk("t3_out_last", 32'(olast), (bi == 2) ? 1 : 0);
         if (pat[c]) bi++;
         cyc();
      end
      lvalid = '0;
      llast  = '0;
      oready = 1'b1;
      settle();
      chk("t3_released", 32'(sel_valid), 0);
      chk("t3_count_drained", 32'(dm_count(1)), 0);

      // Commit and drain on lane 1 in the same cycle
      commit = 4'b0010;
      lvalid = 4'b0010;
      llast  = 4'b0010;
      cyc();
      commit = '0;
      settle();
      expect_grant(1);
      commit = 4'b0010;
      settle();
      chk("t4_count_before", 32'(dm_count(1)), 1);
      cyc();
      commit = '0;
      settle();
      chk("t4_count_net", 32'(dm_count(1)), 1);
      chk("t4_bubble", 32'(sel_valid), 0);
      cyc();
      settle();
      chk("t4_regrant_valid", 32'(sel_valid), 1);
      chk("t4_regrant_lane", 32'(sel), 1);
      cyc();
      lvalid = '0;
      llast  = '0;
      settle();
      chk("t4_count_drained", 32'(dm_count(1)), 0);
      chk("t4_released", 32'(sel_valid), 0);

      // Overflow: three commits to lane 0, no drain
      commit = 4'b0001;
      cyc();
      settle();
      chk("t5_count1", 32'(dm_count(0)), 1);
      chk("t5_ovf_early", 32'(ovf), 0);
      cyc();
      settle();
      chk("t5_count2", 32'(dm_count(0)), 2);
      chk("t5_ovf_at_full", 32'(ovf), 0);
      cyc();
      commit = '0;
      settle();
      chk("t5_count_held", 32'(dm_count(0)), 2);
      chk("t5_ovf_set", 32'(ovf), 1);
      cyc();
      cyc();
      settle();
      chk("t5_ovf_sticky", 32'(ovf), 1);
      chk("t5_stall_grant", 32'(sel_valid), 1);
      chk("t5_stall_lane", 32'(sel), 0);
      chk("t5_stall_no_valid", 32'(ovalid), 0);

      // Reset in the middle of a 5-beat packet on lane 2
      do_reset();
      chk("t6_ovf_cleared", 32'(ovf), 0);
      commit = 4'b0100;
      lvalid = 4'b0100;
      oready = 1'b1;
      cyc();
      commit = '0;
      settle();
      expect_grant(2);
      cyc();
      settle();
      chk("t6_beat2_valid", 32'(ovalid), 1);
      rst_ni = 1'b0;
      #1;
      chk("t6_async_sel_valid", 32'(sel_valid), 0);
      chk("t6_async_out_valid", 32'(ovalid), 0);
      chk("t6_async_out_last", 32'(olast), 0);
      chk("t6_async_lane_ready", 32'(lready), 0);
      chk("t6_async_sel", 32'(sel), 0);
      chk("t6_async_count", 32'(dm_count(2)), 0);
      cyc();
      cyc();
      rst_ni = 1'b1;
      cyc();
      cyc();
      settle();
      chk("t6_no_grant_after_rst", 32'(sel_valid), 0);
      chk("t6_no_valid_after_rst", 32'(ovalid), 0);
      commit = 4'b0100;
      cyc();
      commit = '0;
      settle();
      chk("t6_decision_cycle", 32'(sel_valid), 0);
      cyc();
      settle();
      chk("t6_regrant_valid", 32'(sel_valid), 1);
      chk("t6_regrant_lane", 32'(sel), 2);
      lvalid = '0;

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   function automatic logic [31:0] dm_count(input int lane);
      return 32'(dut.pkt_count_r[lane]);
   endfunction

endmodule
